kbd_event_ctrl: RTL and testbench
=================================

KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, SHALL set the cycles an unresolved E0/F0 prefix is held before it is discarded.
REQ-002 Parameter SUPPRESS_REPEAT, default 1, SHALL suppress typematic repeat makes when 1.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 ps2_data_i  in  8  head byte of the PS/2 receiver FIFO.
REQ-006 ps2_ready_i  in  1  FIFO non-empty.
REQ-007 ps2_overflow_i  in  1  receiver FIFO overflow flag.
REQ-008 ps2_nextdata_n_o  out  1  registered, active-low pop strobe to receiver.
REQ-009 evt_valid_o  out  1  key event available.
REQ-010 evt_ready_i  in  1  consumer accepts event.
REQ-011 evt_code_o  out  8  scan code of event.
REQ-012 evt_ext_o / evt_brk_o  out  1 each  E0-extended / break (release) flags.
REQ-013 held_o  out  1  a key is currently held.
REQ-014 key_cnt_o  out  8  count of distinct key presses, binary.
REQ-015 ovf_sticky_o  out  1  sticky overflow indicator.
REQ-016 ovf_clr_i  in  1  clears ovf_sticky_o.

Function
REQ-017 FSM states SHALL be IDLE, POP, EMIT.
REQ-018 IDLE: on ps2_ready_i=1, latch ps2_data_i into byte register, go POP; else stay.
REQ-019 POP: ps2_nextdata_n_o=0 for exactly this one cycle, byte decoded; ps2_nextdata_n_o=1 in every other state/cycle.
REQ-020 Decode: E0 sets ext_pend, F0 sets brk_pend, POP->IDLE, no event.
REQ-021 Decode: 00, FF, AA, FA, EE, FE discarded, prefix flags cleared, POP->IDLE.
REQ-022 Decode: any other byte forms event {code, ext_pend, brk_pend}, prefix flags cleared, POP->EMIT unless suppressed (REQ-024), then POP->IDLE.
REQ-023 Make of key differing from held key {code,ext}: key_cnt_o+1 (wraps FF->00), held key register updated, held_o=1.
REQ-024 Make equal to held key while held_o=1: repeat; key_cnt_o unchanged; no event when SUPPRESS_REPEAT=1, event emitted otherwise.
REQ-025 Break equal to held key: held_o=0; break of other key: held state unchanged; break always emitted.
REQ-026 EMIT: evt_valid_o=1 with evt_code_o/evt_ext_o/evt_brk_o stable until cycle with evt_ready_i=1, then IDLE; no pop while in EMIT.
REQ-027 Minimum throughput 2 cycles per discarded/prefix byte, 3 cycles per emitted event with evt_ready_i=1.
REQ-028 Prefix timer counts IDLE cycles while ext_pend|brk_pend; at TIMEOUT_CYCLES both flags clear; timer clears on any latched byte.
REQ-029 ps2_overflow_i rising edge SHALL set ovf_sticky_o and clear prefix flags; ovf_clr_i clears it; simultaneous set and clear -> set wins.
REQ-030 evt_* outputs SHALL be 0 whenever evt_valid_o=0.

Reset
REQ-031 rst_i SHALL force, asynchronously: state IDLE, ps2_nextdata_n_o=1, evt_valid_o=0, evt_code_o=0, evt_ext_o=0, evt_brk_o=0, held_o=0, key_cnt_o=0, ovf_sticky_o=0, prefix flags and timer 0.
REQ-032 Reset asserted mid-EMIT or mid-POP SHALL drop the pending event/byte; the first post-reset pop requires a fresh IDLE cycle.

Structure
REQ-033 Shared package kbd_pkg SHALL hold state enum and scan-code constants (E0, F0, discard codes).
REQ-034 Single module, no sub-module; prefix timer inline, width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-035 Bytes 1C, F0, 1C, evt_ready_i=1 -> events {1C,ext0,brk0},{1C,ext0,brk1}; key_cnt_o 0->1; held_o 1 then 0; three one-cycle pops.
REQ-036 Bytes E0 75, E0 F0 75 -> events {75,ext1,brk0},{75,ext1,brk1}; key_cnt_o=1.
REQ-037 SUPPRESS_REPEAT=1, bytes 1C 1C 1C F0 1C -> exactly 2 events, key_cnt_o=1; with 0 -> 4 events, key_cnt_o=1.
REQ-038 evt_ready_i=0 for 10 cycles with ps2_ready_i=1 -> evt_valid_o held, evt_code_o stable, ps2_nextdata_n_o stays 1.
REQ-039 TIMEOUT_CYCLES=16: F0, idle 16 cycles, 1C -> make event {1C,brk0}; F0, idle 15 cycles, 1C -> break event.
REQ-040 Overflow pulse coincident with ovf_clr_i -> ovf_sticky_o=1; rst_i during EMIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared FSM state type and PS/2 scan-code constants for kbd_event_ctrl
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_ERR0 = 8'h00;
    localparam logic [7:0] SC_ERR1 = 8'hFF;
    localparam logic [7:0] SC_BAT  = 8'hAA;
    localparam logic [7:0] SC_ACK  = 8'hFA;
    localparam logic [7:0] SC_ECHO = 8'hEE;
    localparam logic [7:0] SC_RSND = 8'hFE;

    // Keyboard housekeeping replies that never describe a key.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERR1) || (b == SC_BAT) ||
               (b == SC_ACK)  || (b == SC_ECHO) || (b == SC_RSND);
    endfunction

endpackage

// File: rtl/kbd_event_ctrl.sv
// rtl/kbd_event_ctrl.sv - PS/2 scan-code byte decoder producing make/break key events
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter bit          SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ps2_data_i,
    input  logic       ps2_ready_i,
    input  logic       ps2_overflow_i,
    output logic       ps2_nextdata_n_o,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [7:0] evt_code_o,
    output logic       evt_ext_o,
    output logic       evt_brk_o,
    output logic       held_o,
    output logic [7:0] key_cnt_o,
    output logic       ovf_sticky_o,
    input  logic       ovf_clr_i
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic [7:0]       byte_q;
    logic             ext_pend_q;
    logic             brk_pend_q;
    logic [TMR_W-1:0] tmr_q;
    logic [7:0]       held_code_q;
    logic             held_ext_q;
    logic             ovf_prev_q;

    logic ovf_rise;
    logic held_match;
    logic is_repeat;

    assign ovf_rise   = ps2_overflow_i & ~ovf_prev_q;
    assign held_match = held_o & (byte_q == held_code_q) & (ext_pend_q == held_ext_q);
    assign is_repeat  = ~brk_pend_q & held_match;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            byte_q           <= '0;
            ext_pend_q       <= 1'b0;
            brk_pend_q       <= 1'b0;
            tmr_q            <= '0;
            held_code_q      <= '0;
            held_ext_q       <= 1'b0;
            ovf_prev_q       <= 1'b0;
            ps2_nextdata_n_o <= 1'b1;
            evt_valid_o      <= 1'b0;
            evt_code_o       <= '0;
            evt_ext_o        <= 1'b0;
            evt_brk_o        <= 1'b0;
            held_o           <= 1'b0;
            key_cnt_o        <= '0;
            ovf_sticky_o     <= 1'b0;
        end else begin
            ovf_prev_q       <= ps2_overflow_i;
            ps2_nextdata_n_o <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (ps2_ready_i) begin
                        byte_q           <= ps2_data_i;
                        tmr_q            <= '0;
                        ps2_nextdata_n_o <= 1'b0;
                        state_q          <= ST_POP;
                    end else if (ext_pend_q | brk_pend_q) begin
                        // A prefix whose key byte never arrives is dropped.
                        if (tmr_q == TMR_LAST) begin
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                            tmr_q      <= '0;
                        end else begin
                            tmr_q <= tmr_q + TMR_W'(1);
                        end
                    end
                end
                ST_POP: begin
                    state_q <= ST_IDLE;
                    if (byte_q == SC_EXT) begin
                        ext_pend_q <= 1'b1;
                    end else if (byte_q == SC_BRK) begin
                        brk_pend_q <= 1'b1;
                    end else begin
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                        if (!is_discard(byte_q)) begin
                            if (brk_pend_q) begin
                                if (held_match) held_o <= 1'b0;
                            end else if (!is_repeat) begin
                                key_cnt_o   <= key_cnt_o + 8'd1;
                                held_code_q <= byte_q;
                                held_ext_q  <= ext_pend_q;
                                held_o      <= 1'b1;
                            end
                            if (!(is_repeat && SUPPRESS_REPEAT)) begin
                                evt_valid_o <= 1'b1;
                                evt_code_o  <= byte_q;
                                evt_ext_o   <= ext_pend_q;
                                evt_brk_o   <= brk_pend_q;
                                state_q     <= ST_EMIT;
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (evt_ready_i) begin
                        evt_valid_o <= 1'b0;
                        evt_code_o  <= '0;
                        evt_ext_o   <= 1'b0;
                        evt_brk_o   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // Lost bytes make any half-received prefix meaningless.
            if (ovf_rise) begin
                ovf_sticky_o <= 1'b1;
                ext_pend_q   <= 1'b0;
                brk_pend_q   <= 1'b0;
                tmr_q        <= '0;
            end else if (ovf_clr_i) begin
                ovf_sticky_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// tb/tb_kbd_event_ctrl.sv - self-checking bench for kbd_event_ctrl
module tb_kbd_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       evt_ready;
    logic       ovf_clr;

    logic       a_nd, a_valid, a_ext, a_brk, a_held, a_sticky;
    logic [7:0] a_code, a_cnt;
    logic       b_nd, b_valid, b_ext, b_brk, b_held, b_sticky;
    logic [7:0] b_code, b_cnt;

    always #5 clk = ~clk;

    kbd_event_ctrl #(.TIMEOUT_CYCLES(16), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .ps2_data_i(ps2_data), .ps2_ready_i(ps2_ready),
        .ps2_overflow_i(ps2_overflow), .ps2_nextdata_n_o(a_nd), .evt_valid_o(a_valid),
        .evt_ready_i(evt_ready), .evt_code_o(a_code), .evt_ext_o(a_ext), .evt_brk_o(a_brk),
        .held_o(a_held), .key_cnt_o(a_cnt), .ovf_sticky_o(a_sticky), .ovf_clr_i(ovf_clr)
    );

    kbd_event_ctrl #(.TIMEOUT_CYCLES(16), .SUPPRESS_REPEAT(1'b0)) dut_r (
        .clk_i(clk), .rst_i(rst), .ps2_data_i(ps2_data), .ps2_ready_i(ps2_ready),
        .ps2_overflow_i(ps2_overflow), .ps2_nextdata_n_o(b_nd), .evt_valid_o(b_valid),
        .evt_ready_i(evt_ready), .evt_code_o(b_code), .evt_ext_o(b_ext), .evt_brk_o(b_brk),
        .held_o(b_held), .key_cnt_o(b_cnt), .ovf_sticky_o(b_sticky), .ovf_clr_i(ovf_clr)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] evq[$];
    logic [9:0] b_last;
    int         ev_b, pops, b_pops, long_pop, cyc, q0, good, n;
    int         pop_t[$];
    logic       prev_pop;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_valid && evt_ready) evq.push_back({a_code, a_ext, a_brk});
        if (b_valid && evt_ready) begin
            ev_b++;
            b_last = {b_code, b_ext, b_brk};
        end
        if (!a_nd) begin
            pops++;
            pop_t.push_back(cyc);
        end
        if (!b_nd) b_pops++;
        if (!a_nd && prev_pop) long_pop++;
        prev_pop = !a_nd;
    end

    function automatic logic [9:0] ev(input logic [7:0] c, input logic e, input logic b);
        return {c, e, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ps2_ready = 1'b0;
        ps2_data = 8'h00;
        ps2_overflow = 1'b0;
        ovf_clr = 1'b0;
        evt_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        evq.delete();
        pop_t.delete();
        ev_b = 0; pops = 0; b_pops = 0; long_pop = 0; b_last = '0;
    endtask

    // Present one byte, return at the negedge of its pop cycle with ready dropped.
    task automatic send(input logic [7:0] b);
        int k = 0;
        ps2_data = b;
        ps2_ready = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (a_nd !== 1'b0 && k < 40);
        if (a_nd !== 1'b0) chk("send_pop_timeout", a_nd, 0);
        ps2_ready = 1'b0;
    endtask

    task automatic send_spaced(input logic [7:0] b);
        send(b);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [23:0] bytes;
        int          nb;
        logic [9:0]  evt;
        logic        held;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{24'h1C0000, 1, ev(8'h1C, 1'b0, 1'b0), 1'b1, 8'd1};
        vt[1] = '{24'hF01C00, 2, ev(8'h1C, 1'b0, 1'b1), 1'b0, 8'd1};
        vt[2] = '{24'hE07500, 2, ev(8'h75, 1'b1, 1'b0), 1'b1, 8'd2};
        vt[3] = '{24'hE0F075, 3, ev(8'h75, 1'b1, 1'b1), 1'b0, 8'd2};
        vt[4] = '{24'h750000, 1, ev(8'h75, 1'b0, 1'b0), 1'b1, 8'd3};
        vt[5] = '{24'hE07500, 2, ev(8'h75, 1'b1, 1'b0), 1'b1, 8'd4};
        vt[6] = '{24'hF07500, 2, ev(8'h75, 1'b0, 1'b1), 1'b1, 8'd4};
        vt[7] = '{24'hF0001C, 3, ev(8'h1C, 1'b0, 1'b0), 1'b1, 8'd5};
        vt[8] = '{24'hE0AA5A, 3, ev(8'h5A, 1'b0, 1'b0), 1'b1, 8'd6};
        vt[9] = '{24'hF0E05A, 3, ev(8'h5A, 1'b1, 1'b1), 1'b1, 8'd6};

        do_reset();
        repeat (2) @(negedge clk);
        chk("rst_nextdata_n", a_nd, 1);
        chk("rst_valid", a_valid, 0);
        chk("rst_evt", {a_code, a_ext, a_brk}, 0);
        chk("rst_held", a_held, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_sticky", a_sticky, 0);

        for (int i = 0; i < 10; i++) begin
            q0 = evq.size();
            for (int k = 0; k < vt[i].nb; k++) send(vt[i].bytes[23-8*k -: 8]);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_nevents", i), evq.size() - q0, 1);
            chk($sformatf("vec%0d_event", i), (evq.size() > q0) ? evq[evq.size()-1] : 10'h3FF, vt[i].evt);
            chk($sformatf("vec%0d_held", i), a_held, vt[i].held);
            chk($sformatf("vec%0d_cnt", i), a_cnt, vt[i].cnt);
            chk($sformatf("vec%0d_idle_evt_zero", i), {a_valid, a_code, a_ext, a_brk}, 0);
        end
        chk("vec_pops_one_cycle", long_pop, 0);

        // Repeat handling: suppressing instance vs. repeat-emitting instance.
        do_reset();
        send_spaced(8'h1C); send_spaced(8'h1C); send_spaced(8'h1C);
        send_spaced(8'hF0); send_spaced(8'h1C);
        chk("rep_sup_events", evq.size(), 2);
        chk("rep_sup_last", (evq.size() == 2) ? evq[1] : 10'h3FF, ev(8'h1C, 1'b0, 1'b1));
        chk("rep_sup_cnt", a_cnt, 1);
        chk("rep_sup_held", a_held, 0);
        chk("rep_emit_events", ev_b, 4);
        chk("rep_emit_cnt", b_cnt, 1);
        chk("rep_emit_held", b_held, 0);
        chk("rep_emit_last", b_last, ev(8'h1C, 1'b0, 1'b1));
        chk("rep_pops", pops, 5);
        chk("rep_emit_pops", b_pops, 5);

        // Back-to-back throughput: prefix 2 cycles, event 3 cycles, discard 2 cycles.
        do_reset();
        send(8'hE0); send(8'h75); send(8'h00); send(8'h1C);
        repeat (3) @(negedge clk);
        chk("tput_npops", pop_t.size(), 4);
        if (pop_t.size() == 4) begin
            chk("tput_prefix", pop_t[1] - pop_t[0], 2);
            chk("tput_event", pop_t[2] - pop_t[1], 3);
            chk("tput_discard", pop_t[3] - pop_t[2], 2);
        end
        chk("tput_nevents", evq.size(), 2);
        chk("tput_ev0", (evq.size() > 0) ? evq[0] : 10'h3FF, ev(8'h75, 1'b1, 1'b0));
        chk("tput_long_pop", long_pop, 0);

        // Consumer stall with more bytes waiting.
        do_reset();
        @(posedge clk); #1 evt_ready = 1'b0;
        send(8'h1C);
        ps2_data = 8'h32;
        ps2_ready = 1'b1;
        good = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_valid === 1'b1 && a_code === 8'h1C && a_nd === 1'b1) good++;
        end
        chk("stall_hold_cycles", good, 10);
        @(posedge clk); #1 evt_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (a_nd !== 1'b0 && n < 10);
        chk("stall_resume_pop", a_nd, 0);
        ps2_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_nevents", evq.size(), 2);
        chk("stall_ev1", (evq.size() == 2) ? evq[1] : 10'h3FF, ev(8'h32, 1'b0, 1'b0));

        // Prefix timeout boundary: N ready-low IDLE cycles needs N+1 negedge waits.
        do_reset();
        send(8'hF0);
        repeat (17) @(negedge clk);
        send(8'h1C);
        repeat (3) @(negedge clk);
        chk("tmo_expired_evt", (evq.size() > 0) ? evq[evq.size()-1] : 10'h3FF, ev(8'h1C, 1'b0, 1'b0));
        chk("tmo_expired_held", a_held, 1);
        send(8'hF0);
        repeat (16) @(negedge clk);
        send(8'h1C);
        repeat (3) @(negedge clk);
        chk("tmo_live_evt", (evq.size() > 0) ? evq[evq.size()-1] : 10'h3FF, ev(8'h1C, 1'b0, 1'b1));
        chk("tmo_live_held", a_held, 0);

        // Overflow sticky flag and prefix flush.
        do_reset();
        ps2_overflow = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", a_sticky, 1);
        @(negedge clk);
        chk("ovf_level_holds", a_sticky, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", a_sticky, 0);
        ps2_overflow = 1'b0;
        @(negedge clk);
        send(8'hE0);
        ps2_overflow = 1'b1;
        @(negedge clk);
        ps2_overflow = 1'b0;
        send(8'h75);
        repeat (3) @(negedge clk);
        chk("ovf_prefix_flushed", (evq.size() > 0) ? evq[evq.size()-1] : 10'h3FF, ev(8'h75, 1'b0, 1'b0));
        chk("ovf_sticky_again", a_sticky, 1);
        chk("ovf_sticky_r", b_sticky, 1);

        // Asynchronous reset while an event is pending.
        do_reset();
        @(posedge clk); #1 evt_ready = 1'b0;
        send(8'h1C);
        @(negedge clk);
        chk("arst_pre_valid", a_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", a_valid, 0);
        chk("arst_evt", {a_code, a_ext, a_brk}, 0);
        chk("arst_held_cnt", {a_held, a_cnt}, 0);
        chk("arst_nextdata_n", a_nd, 1);
        @(negedge clk);
        rst = 1'b0;
        evt_ready = 1'b1;
        q0 = evq.size();
        repeat (3) @(negedge clk);
        chk("arst_event_dropped", evq.size() - q0, 0);
        chk("arst_idle_nextdata_n", a_nd, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
